// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN streaming pipeline stages.
// Holds the default counter widths of the pooling stage and the
// requantising shift/saturate helper used by every requantising stage.
package cnn_stream_pkg;

    // Width of a counter that must index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    // Default geometry of the stage that follows multich_conv2d.
    localparam int POOL_C_DEF     = 8;
    localparam int POOL_W_IN_DEF  = 62;
    localparam int POOL_H_IN_DEF  = 62;

    // Counter widths for the default geometry.
    localparam int POOL_CH_CNT_W  = $clog2(POOL_C_DEF);
    localparam int POOL_COL_CNT_W = $clog2(POOL_W_IN_DEF);
    localparam int POOL_ROW_CNT_W = $clog2(POOL_H_IN_DEF);

    // Arithmetic (floor) right shift followed by saturation to a signed
    // out_w-bit range. The result is returned sign-extended to 32 bits.
    function automatic logic signed [31:0] sat_shift(
        input logic signed [31:0] value,
        input int                 shift,
        input int                 out_w
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] res;
        s  = value >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) begin
            res = hi;
        end else if (s < lo) begin
            res = lo;
        end else begin
            res = s;
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for the 2x2 pooler: one pooled-column slot per channel,
// holding the horizontal max of the even row until the odd row consumes it.
// One synchronous write port, one combinational read port; contents are
// never reset because every slot is written on an even row before it is read.
module pool_line_buf
    import cnn_stream_pkg::*;
#(
    parameter int DEPTH = 248,
    parameter int IN_W  = 16,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [IN_W-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [IN_W-1:0] o_rdata
);

    logic [IN_W-1:0] r_mem [DEPTH];

    // Store the even-row horizontal max for later use on the odd row.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_maxpool2x2_requant.sv
// 2x2 / stride-2 per-channel max pooling with arithmetic-shift requantisation
// and saturation on a channel-interleaved raster stream (ch fastest).
// Optional feature macro: POOL_RELU_EN -- clamps the pooled max to zero when
// negative before the shift, so outputs fall in [0, 2^(OUT_W-1)-1].
module stream_maxpool2x2_requant
    import cnn_stream_pkg::*;
#(
    parameter int C     = 8,
    parameter int H_IN  = 62,
    parameter int W_IN  = 62,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  pixel_in,
    input  logic             valid_in,
    input  logic             last_in,
    output logic [OUT_W-1:0] pixel_out,
    output logic             valid_out,
    output logic             done
);

    localparam int CH_W     = cnt_width(C);
    localparam int COL_W    = cnt_width(W_IN);
    localparam int ROW_W    = cnt_width(H_IN);
    // Odd trailing row / column never completes a window.
    localparam int ROW_LIM  = (H_IN / 2) * 2;
    localparam int COL_LIM  = (W_IN / 2) * 2;
    localparam int LB_DEPTH = (W_IN / 2) * C;
    localparam int LB_AW    = cnt_width(LB_DEPTH);

    logic [CH_W-1:0]         r_ch;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic signed [IN_W-1:0]  r_hreg [C];

    logic signed [IN_W-1:0]  w_x;
    logic [IN_W-1:0]         w_lb_rdata;
    logic signed [IN_W-1:0]  w_cmp;
    logic signed [IN_W-1:0]  w_max;
    logic signed [IN_W-1:0]  w_hreg_d;
    logic signed [31:0]      w_m32;
    logic [OUT_W-1:0]        w_q;
    logic [LB_AW-1:0]        w_lb_addr;
    logic                    w_ch_last;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_frame_end;
    logic                    w_in_win;
    logic                    w_active;
    logic                    w_row_odd;
    logic                    w_col_odd;
    logic                    w_emit;
    logic                    w_lb_we;
    logic                    w_hreg_we;

    // Position decode, window datapath and requantisation of the current sample.
    always_comb begin
        w_x         = $signed(pixel_in);
        w_ch_last   = (r_ch  == CH_W'(C - 1));
        w_col_last  = (r_col == COL_W'(W_IN - 1));
        w_row_last  = (r_row == ROW_W'(H_IN - 1));
        w_frame_end = last_in || (w_row_last && w_col_last && w_ch_last);
        w_in_win    = ({1'b0, r_row} < (ROW_W + 1)'(ROW_LIM)) &&
                      ({1'b0, r_col} < (COL_W + 1)'(COL_LIM));
        w_active    = valid_in && w_in_win;
        w_row_odd   = r_row[0];
        w_col_odd   = r_col[0];
        w_emit      = w_active && w_row_odd && w_col_odd;
        w_lb_we     = !rst && w_active && !w_row_odd && w_col_odd;
        w_hreg_we   = !rst && w_active && !w_col_odd;
        w_lb_addr   = LB_AW'((int'(r_col) >> 1) * C + int'(r_ch));

        // Even column of an odd row compares against the stored even-row max;
        // every other position compares against the per-channel holding reg.
        if (w_row_odd && !w_col_odd) begin
            w_cmp = $signed(w_lb_rdata);
        end else begin
            w_cmp = r_hreg[r_ch];
        end

        if (w_x > w_cmp) begin
            w_max = w_x;
        end else begin
            w_max = w_cmp;
        end

        // Even row starts a fresh window half; odd row folds in the line buffer.
        if (w_row_odd) begin
            w_hreg_d = w_max;
        end else begin
            w_hreg_d = w_x;
        end

        w_m32 = 32'(w_max);
`ifdef POOL_RELU_EN
        if (w_m32 < 32'sd0) begin
            w_m32 = 32'sd0;
        end else begin
            w_m32 = w_m32;
        end
`else
        w_m32 = w_m32;
`endif
        w_q = OUT_W'(sat_shift(w_m32, SHIFT, OUT_W));
    end

    // Per-channel holding register: horizontal partial max of the window.
    always_ff @(posedge clk) begin
        if (w_hreg_we) begin
            r_hreg[r_ch] <= w_hreg_d;
        end
    end

    // Position counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch      <= '0;
            r_col     <= '0;
            r_row     <= '0;
            pixel_out <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= w_emit;
            done      <= valid_in && last_in;
            if (w_emit) begin
                pixel_out <= w_q;
            end
            if (valid_in) begin
                if (w_frame_end) begin
                    r_ch  <= '0;
                    r_col <= '0;
                    r_row <= '0;
                end else if (!w_ch_last) begin
                    r_ch <= r_ch + CH_W'(1);
                end else begin
                    r_ch <= '0;
                    if (!w_col_last) begin
                        r_col <= r_col + COL_W'(1);
                    end else begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end
                end
            end
        end
    end

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .IN_W  (IN_W),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_max),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

endmodule

// File: tb/tb_stream_maxpool2x2_requant.sv
// Self-checking bench for stream_maxpool2x2_requant.
// Group 0: two 4x4x2 instances (SHIFT=0 and SHIFT=2) share one stream.
// Group 1: one 5x5x2 instance (SHIFT=0) for odd-size trimming.
// Expected values come from a frame-array reference model.
module tb_stream_maxpool2x2_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pix_in;
    logic        va;
    logic        vb;
    logic        last_in;
    logic [7:0]  p0, p2, p5;
    logic        v0, v2, v5;
    logic        d0, d2, d5;

    always #5 clk = ~clk;

    stream_maxpool2x2_requant #(.C(2), .H_IN(4), .W_IN(4), .IN_W(16), .OUT_W(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .pixel_in(pix_in), .valid_in(va), .last_in(last_in),
        .pixel_out(p0), .valid_out(v0), .done(d0));

    stream_maxpool2x2_requant #(.C(2), .H_IN(4), .W_IN(4), .IN_W(16), .OUT_W(8), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .pixel_in(pix_in), .valid_in(va), .last_in(last_in),
        .pixel_out(p2), .valid_out(v2), .done(d2));

    stream_maxpool2x2_requant #(.C(2), .H_IN(5), .W_IN(5), .IN_W(16), .OUT_W(8), .SHIFT(0)) dut5 (
        .clk(clk), .rst(rst), .pixel_in(pix_in), .valid_in(vb), .last_in(last_in),
        .pixel_out(p5), .valid_out(v5), .done(d5));

    int checks   = 0;
    int failures = 0;

    // reference model state
    int frm [2][8][8][2];
    int pr [2];
    int pc [2];
    int pch [2];
    int gh [2] = '{4, 5};
    int gw [2] = '{4, 5};
    int ev [2];
    int ed [2];
    int ep0, ep2, ep5;
    bit capture = 1'b0;
    int capq [$];

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rq(input int m_in, input int sh);
        int m;
        int s;
        m = m_in;
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        s = m >>> sh;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One clock: drive inputs, update the model, check outputs #1 after the edge.
    task automatic step(input bit a, input bit b, input int x, input bit l, input bit r);
        bit v;
        int rr, cc, kk, m;
        va = a; vb = b; pix_in = x[15:0]; last_in = l; rst = r;
        if (r) begin
            for (int g = 0; g < 2; g++) begin
                pr[g] = 0; pc[g] = 0; pch[g] = 0; ev[g] = 0; ed[g] = 0;
            end
            ep0 = 0; ep2 = 0; ep5 = 0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                v = (g == 0) ? a : b;
                ev[g] = 0;
                ed[g] = 0;
                if (v) begin
                    rr = pr[g]; cc = pc[g]; kk = pch[g];
                    frm[g][rr][cc][kk] = x;
                    if (rr % 2 == 1 && cc % 2 == 1 && rr < (gh[g] / 2) * 2 && cc < (gw[g] / 2) * 2) begin
                        m = imax(imax(frm[g][rr-1][cc-1][kk], frm[g][rr-1][cc][kk]),
                                 imax(frm[g][rr][cc-1][kk], x));
                        ev[g] = 1;
                        if (g == 0) begin
                            ep0 = rq(m, 0);
                            ep2 = rq(m, 2);
                        end else begin
                            ep5 = rq(m, 0);
                        end
                    end
                    ed[g] = l ? 1 : 0;
                    if (l || (rr == gh[g] - 1 && cc == gw[g] - 1 && kk == 1)) begin
                        pr[g] = 0; pc[g] = 0; pch[g] = 0;
                    end else if (kk < 1) begin
                        pch[g] = kk + 1;
                    end else begin
                        pch[g] = 0;
                        if (cc < gw[g] - 1) pc[g] = cc + 1;
                        else begin pc[g] = 0; pr[g] = rr + 1; end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("valid0", v0, ev[0]);
        check_eq("pix0",   $signed(p0), ep0);
        check_eq("done0",  d0, ed[0]);
        check_eq("valid2", v2, ev[0]);
        check_eq("pix2",   $signed(p2), ep2);
        check_eq("done2",  d2, ed[0]);
        check_eq("valid5", v5, ev[1]);
        check_eq("pix5",   $signed(p5), ep5);
        check_eq("done5",  d5, ed[1]);
        if (capture && v0 === 1'b1) capq.push_back(int'($signed(p0)));
    endtask

    function automatic int sample(input int kind, input int r, input int c, input int k);
        int nm [4];
        nm = '{-5, -3, -9, -7};
        case (kind)
            0: return 16 * r + 4 * c + k;
            1: return 300;
            2: return -1000;
            4: return (k == 0 && r < 2 && c < 2) ? nm[r * 2 + c] : int'($urandom_range(0, 65535)) - 32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Drive one frame; last_at/rst_at are sample indices (-1 = none).
    task automatic frame(input int g, input int kind, input bit gaps, input int last_at, input int rst_at);
        int n;
        int x;
        bit lst;
        n = 0;
        for (int r = 0; r < gh[g]; r++) begin
            for (int c = 0; c < gw[g]; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (n == rst_at) begin
                        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
                        return;
                    end
                    if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
                    x = sample(kind, r, c, k);
                    lst = (n == last_at) || (last_at < 0 && r == gh[g] - 1 && c == gw[g] - 1 && k == 1);
                    step(g == 0, g == 1, x, lst, 1'b0);
                    if (lst) return;
                    n++;
                end
            end
        end
    endtask

    task automatic check_ramp_capture(input string tag);
        int ramp [8];
        ramp = '{20, 21, 28, 29, 52, 53, 60, 61};
        check_eq({tag, "_count"}, capq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < capq.size()) check_eq(tag, capq[i], ramp[i]);
        end
        capq.delete();
    endtask

    initial begin
        va = 1'b0; vb = 1'b0; pix_in = '0; last_in = 1'b0; rst = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // ramp, then back-to-back ramp with no bubble
        capture = 1'b1;
        frame(0, 0, 1'b0, -1, -1);
        check_ramp_capture("ramp");
        frame(0, 0, 1'b0, -1, -1);
        check_ramp_capture("ramp_b2b");

        // short frame ending at (1,1,1), then a full ramp
        frame(0, 0, 1'b0, 11, -1);
        check_eq("short_count", capq.size(), 2);
        capq.delete();
        frame(0, 0, 1'b0, -1, -1);
        check_ramp_capture("ramp_after_short");

        // gappy ramp
        frame(0, 0, 1'b1, -1, -1);
        check_ramp_capture("ramp_gappy");

        // saturation
        frame(0, 1, 1'b0, -1, -1);
`ifdef POOL_RELU_EN
        if (capq.size() > 0) check_eq("sat_pos", capq[0], 127);
`else
        if (capq.size() > 0) check_eq("sat_pos", capq[0], 127);
`endif
        check_eq("sat_count", capq.size(), 8);
        capq.delete();
        frame(0, 2, 1'b0, -1, -1);
        capq.delete();

        // negative max window on ch0
        frame(0, 4, 1'b0, -1, -1);
        check_eq("negmax_count", capq.size(), 8);
`ifdef POOL_RELU_EN
        if (capq.size() > 0) check_eq("negmax", capq[0], 0);
`else
        if (capq.size() > 0) check_eq("negmax", capq[0], -3);
`endif
        capq.delete();

        // reset at (2,1,0), then a fresh ramp
        frame(0, 0, 1'b0, -1, 18);
        capq.delete();
        frame(0, 0, 1'b0, -1, -1);
        check_ramp_capture("ramp_after_rst");
        capture = 1'b0;

        // randomized frames with gaps
        for (int i = 0; i < 6; i++) frame(0, 3, 1'b1, -1, -1);

        // odd 5x5 geometry
        frame(1, 0, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++) frame(1, 3, (i % 2) == 1, -1, -1);

        repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
